// File: rtl/sevenseg_mux_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment driver with per-slot blanking
// and frame-atomic data capture. Optional PWM dimming under SEVENSEG_BRIGHTNESS_PWM_EN.
module sevenseg_mux_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 32768,
  parameter int BLANK_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] dataIn,
  input  logic [NUM_DIGITS-1:0]   digitDisplay,
  input  logic [NUM_DIGITS-1:0]   digitPoint,
`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
  input  logic [3:0]              brightness,
`endif
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_L  = CNT_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0] DIG_MAX  = DIG_W'(NUM_DIGITS - 1);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $fatal(1, "sevenseg_mux_ctrl: NUM_DIGITS must be 1..8");
    end
    if (BLANK_CYCLES < 0 || DWELL_CYCLES <= BLANK_CYCLES) begin : g_bad_timing
      $fatal(1, "sevenseg_mux_ctrl: need 0 <= BLANK_CYCLES < DWELL_CYCLES");
    end
  endgenerate

  logic [CNT_W-1:0]        r_cnt;
  logic [DIG_W-1:0]        r_dig;
  logic [4*NUM_DIGITS-1:0] r_sh_data;
  logic [NUM_DIGITS-1:0]   r_sh_disp;
  logic [NUM_DIGITS-1:0]   r_sh_point;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [6:0]              r_segment;
  logic                    r_dp;
  logic                    r_frame_start;

  logic                    w_capture;
  logic                    w_active;
  logic                    w_lit;
  logic [4*NUM_DIGITS-1:0] w_data;
  logic [NUM_DIGITS-1:0]   w_disp;
  logic [NUM_DIGITS-1:0]   w_point;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic [NUM_DIGITS-1:0]   w_anode;
  logic [3:0]              w_nib;
  logic                    w_en;
  logic                    w_pt;
  logic [6:0]              w_segment;
  logic                    w_dp;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0: f_decode = 7'h40;
      4'h1: f_decode = 7'h79;
      4'h2: f_decode = 7'h24;
      4'h3: f_decode = 7'h30;
      4'h4: f_decode = 7'h19;
      4'h5: f_decode = 7'h12;
      4'h6: f_decode = 7'h02;
      4'h7: f_decode = 7'h78;
      4'h8: f_decode = 7'h00;
      4'h9: f_decode = 7'h10;
      4'hA: f_decode = 7'h08;
      4'hB: f_decode = 7'h03;
      4'hC: f_decode = 7'h46;
      4'hD: f_decode = 7'h21;
      4'hE: f_decode = 7'h06;
      default: f_decode = 7'h0E;
    endcase
  endfunction

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_active = 1'b1;
    end else begin : g_blank
      assign w_active = (r_cnt >= BLANK_L);
    end
  endgenerate

`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
  localparam logic [31:0] WIN = 32'(DWELL_CYCLES - BLANK_CYCLES);
  logic [3:0]  r_sh_bright;
  logic [3:0]  w_bright;
  logic [31:0] w_off;
  logic [31:0] w_thr;
  logic        w_pwm_on;

  always_comb begin
    w_bright = w_capture ? brightness : r_sh_bright;
    w_off    = 32'(r_cnt) - 32'(BLANK_CYCLES);
    w_thr    = (WIN * ({28'd0, w_bright} + 32'd1)) >> 4;
    w_pwm_on = (w_off < w_thr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_bright <= 4'd0;
    end else if (w_capture) begin
      r_sh_bright <= brightness;
    end
  end
`endif

  // The capture cycle drives its own slot from the freshly sampled inputs, so
  // every output cycle of a frame reflects the same captured snapshot.
  always_comb begin
    w_capture = (r_cnt == '0) && (r_dig == '0);
    w_data    = w_capture ? dataIn       : r_sh_data;
    w_disp    = w_capture ? digitDisplay : r_sh_disp;
    w_point   = w_capture ? digitPoint   : r_sh_point;
    w_nib     = 4'd0;
    w_en      = 1'b0;
    w_pt      = 1'b0;
    w_sel     = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (r_dig == DIG_W'(d)) begin
        w_nib    = w_data[4*d +: 4];
        w_en     = w_disp[d];
        w_pt     = w_point[d];
        w_sel[d] = 1'b0;
      end
    end
`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
    w_lit     = w_active && w_en && w_pwm_on;
`else
    w_lit     = w_active && w_en;
`endif
    w_anode   = w_lit ? w_sel : '1;
    w_segment = w_lit ? f_decode(w_nib) : 7'h7F;
    w_dp      = w_lit ? ~w_pt : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_dig         <= '0;
      r_sh_data     <= '0;
      r_sh_disp     <= '0;
      r_sh_point    <= '0;
      r_anode       <= '1;
      r_segment     <= 7'h7F;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      if (r_cnt == DWELL_M1) begin
        r_cnt <= '0;
        r_dig <= (r_dig == DIG_MAX) ? '0 : r_dig + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_capture) begin
        r_sh_data  <= dataIn;
        r_sh_disp  <= digitDisplay;
        r_sh_point <= digitPoint;
      end
      r_frame_start <= w_capture;
      r_anode       <= w_anode;
      r_segment     <= w_segment;
      r_dp          <= w_dp;
    end
  end

  assign anode       = r_anode;
  assign segment     = r_segment;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_sevenseg_mux_ctrl.sv
// Scoreboarded bench for sevenseg_mux_ctrl: a 4-digit and a 1-digit instance
// (plus a PWM instance when SEVENSEG_BRIGHTNESS_PWM_EN is defined).
module tb_sevenseg_mux_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic [3:0]  in_disp;
  logic [3:0]  in_point;

  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        dp;
  logic        frame_start;
  logic        anode1;
  logic [6:0]  segment1;
  logic        dp1;
  logic        fs1;

  logic [12:0] exp_q[$];
  logic [9:0]  exp1_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        chk_en = 1'b0;

  // Bench-side timeline state for each instance
  int          m_cnt = 0;
  int          m_dig = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_disp = '0;
  logic [3:0]  m_point = '0;
  int          m1_cnt = 0;

  sevenseg_mux_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(8), .BLANK_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .dataIn(in_data), .digitDisplay(in_disp), .digitPoint(in_point),
`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
    .brightness(4'hF),
`endif
    .anode(anode), .segment(segment), .dp(dp), .frame_start(frame_start)
  );

  sevenseg_mux_ctrl #(.NUM_DIGITS(1), .DWELL_CYCLES(8), .BLANK_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .dataIn(4'hF), .digitDisplay(1'b1), .digitPoint(1'b0),
`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
    .brightness(4'hF),
`endif
    .anode(anode1), .segment(segment1), .dp(dp1), .frame_start(fs1)
  );

`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
  logic       anode_p;
  logic [6:0] segment_p;
  logic       dp_p;
  logic       fs_p;
  logic [3:0] in_bright;
  logic [9:0] expp_q[$];
  int         mp_cnt = 0;
  logic [3:0] mp_bright = '0;

  sevenseg_mux_ctrl #(.NUM_DIGITS(1), .DWELL_CYCLES(34), .BLANK_CYCLES(2)) u_dutp (
    .clk(clk), .rst(rst), .dataIn(4'h8), .digitDisplay(1'b1), .digitPoint(1'b1),
    .brightness(in_bright),
    .anode(anode_p), .segment(segment_p), .dp(dp_p), .frame_start(fs_p)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_tab(input logic [3:0] n);
    logic [6:0] t[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [12:0] out_vec(int cnt, int dig, logic [15:0] d,
                                          logic [3:0] en, logic [3:0] pt, logic fs);
    logic [3:0] an = 4'hF;
    logic [6:0] sg = 7'h7F;
    logic       p  = 1'b1;
    if (cnt >= 2 && en[dig]) begin
      an[dig] = 1'b0;
      sg      = seg_tab(d[4*dig +: 4]);
      p       = ~pt[dig];
    end
    return {an, sg, p, fs};
  endfunction

  // Derive the outputs expected one cycle from now, advance the timeline, then
  // clock the DUTs and queue those expectations for the monitor.
  task automatic step();
    logic        cap;
    logic        cap1;
    logic [15:0] ed;
    logic [3:0]  ee;
    logic [3:0]  ep;
    logic [12:0] ev;
    logic [9:0]  ev1;
`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
    logic        capp;
    logic [3:0]  eb;
    logic        lit;
    logic [9:0]  evp;
`endif
    cap = !rst && m_cnt == 0 && m_dig == 0;
    ed  = cap ? in_data  : m_data;
    ee  = cap ? in_disp  : m_disp;
    ep  = cap ? in_point : m_point;
    ev  = rst ? {4'hF, 7'h7F, 1'b1, 1'b0} : out_vec(m_cnt, m_dig, ed, ee, ep, cap);
    cap1 = !rst && m1_cnt == 0;
    ev1  = rst ? {1'b1, 7'h7F, 1'b1, 1'b0} : {1'b0, 7'h0E, 1'b1, cap1};
    if (rst) begin
      m_cnt = 0; m_dig = 0; m_data = '0; m_disp = '0; m_point = '0; m1_cnt = 0;
    end else begin
      m_data = ed; m_disp = ee; m_point = ep;
      if (m_cnt == 7) begin
        m_cnt = 0;
        m_dig = (m_dig + 1) % 4;
      end else begin
        m_cnt++;
      end
      m1_cnt = (m1_cnt + 1) % 8;
    end
`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
    capp = !rst && mp_cnt == 0;
    eb   = capp ? in_bright : mp_bright;
    lit  = (mp_cnt >= 2) && ((mp_cnt - 2) < (32 * (int'(eb) + 1)) / 16);
    evp  = rst ? {1'b1, 7'h7F, 1'b1, 1'b0}
               : {~lit, (lit ? 7'h00 : 7'h7F), ~lit, capp};
    if (rst) begin
      mp_cnt = 0; mp_bright = '0;
    end else begin
      mp_bright = eb;
      mp_cnt = (mp_cnt + 1) % 34;
    end
`endif
    @(posedge clk);
    #1;
    exp_q.push_back(ev);
    exp1_q.push_back(ev1);
`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
    expp_q.push_back(evp);
`endif
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    logic [12:0] e;
    logic [9:0]  e1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({anode, segment, dp, frame_start} !== e) begin
        n_err++;
        $display("FAIL main t=%0t got an=%b seg=%h dp=%b fs=%b exp an=%b seg=%h dp=%b fs=%b",
                 $time, anode, segment, dp, frame_start, e[12:9], e[8:2], e[1], e[0]);
      end
    end
    if (exp1_q.size() > 0) begin
      e1 = exp1_q.pop_front();
      n_vec++;
      if ({anode1, segment1, dp1, fs1} !== e1) begin
        n_err++;
        $display("FAIL single t=%0t got=%b exp=%b", $time, {anode1, segment1, dp1, fs1}, e1);
      end
    end
`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
    if (expp_q.size() > 0) begin
      e1 = expp_q.pop_front();
      n_vec++;
      if ({anode_p, segment_p, dp_p, fs_p} !== e1) begin
        n_err++;
        $display("FAIL pwm t=%0t got=%b exp=%b", $time, {anode_p, segment_p, dp_p, fs_p}, e1);
      end
    end
`endif
    if (chk_en) begin
      n_vec++;
      if ($countones(~anode) > 1) begin
        n_err++;
        $display("FAIL onehot t=%0t got an=%b exp at most one low bit", $time, anode);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_data  = 16'h1234;
    in_disp  = 4'hF;
    in_point = 4'h0;
`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
    in_bright = 4'd3;
`endif
    run(2);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Two full frames of 1234, all digits on
    run(64);

    // Mid-frame data change at dig=1, cnt=5 must wait for the next capture
    for (int g = 0; g < 64 && !(m_cnt == 5 && m_dig == 1); g++) step();
    in_data = 16'hABCD;
    run(40);

    // Sparse enables with one decimal point; a short data pulse mid-frame is lost
    in_disp  = 4'b0101;
    in_point = 4'b0100;
`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
    in_bright = 4'd15;
`endif
    run(36);
    for (int g = 0; g < 64 && !(m_cnt == 3 && m_dig == 2); g++) step();
    in_data = 16'hFFFF;
    run(3);
    in_data = 16'hABCD;
    run(64);

    // One-cycle reset at dig=2, cnt=6, then a fresh frame with new data
    for (int g = 0; g < 64 && !(m_cnt == 6 && m_dig == 2); g++) step();
    rst = 1'b1;
    in_data = 16'h5A09;
    in_disp = 4'hF;
    step();
    rst = 1'b0;
    run(70);

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size() + exp1_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
